// File: rtl/logcap_cmd_master.sv
// Hub-side command initiator for the logic capture core: drives regIn/command,
// waits for the status acknowledge, captures regOut and clears the handshake.
module logcap_cmd_master #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_opcode,
    input  logic [63:0] req_payload,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [7:0]  rsp_status,
    output logic        rsp_timeout,
    output logic [63:0] cap_reg_in,
    output logic [7:0]  cap_command,
    output logic        cap_command_strobe,
    input  logic [7:0]  cap_status,
    input  logic [63:0] cap_reg_out
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRECLR   = 3'd1;
    localparam logic [2:0] S_PREWAIT  = 3'd2;
    localparam logic [2:0] S_ISSUE    = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;
    localparam logic [2:0] S_CLEAR    = 3'd5;
    localparam logic [2:0] S_WAIT_CLR = 3'd6;
    localparam logic [2:0] S_RESPOND  = 3'd7;

    localparam logic [7:0]      OP_NOP  = 8'h00;
    localparam logic [7:0]      OP_ACK  = 8'h08;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]      state;
    logic [7:0]      opcode_q;
    logic [TO_W-1:0] to_cnt;
    logic            ack;
    logic            to_hit;

    assign ack       = cap_status[3];
    assign to_hit    = (to_cnt == TO_LAST);
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESPOND);

    // Strobes come only from single-cycle states, so they can never be back to back.
    always_comb begin
        cap_command_strobe = 1'b0;
        cap_command        = 8'h00;
        case (state)
            S_PRECLR, S_CLEAR: begin
                cap_command_strobe = 1'b1;
                cap_command        = OP_ACK;
            end
            S_ISSUE: begin
                cap_command_strobe = 1'b1;
                cap_command        = opcode_q;
            end
            default: ;
        endcase
    end

    // The counter rests at zero outside the wait states, so it is clear on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            opcode_q    <= '0;
            cap_reg_in  <= '0;
            to_cnt      <= '0;
            rsp_data    <= '0;
            rsp_status  <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            to_cnt <= '0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        opcode_q   <= req_opcode;
                        cap_reg_in <= req_payload;
                        state      <= ack ? S_PRECLR : S_ISSUE;
                    end
                end
                S_PRECLR: state <= S_PREWAIT;
                S_PREWAIT: begin
                    if (!ack) begin
                        state <= S_ISSUE;
                    end else if (to_hit) begin
                        rsp_timeout <= 1'b1;
                        rsp_data    <= '0;
                        rsp_status  <= cap_status;
                        state       <= S_RESPOND;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_ISSUE: begin
                    if (opcode_q == OP_NOP) begin
                        rsp_data   <= '0;
                        rsp_status <= cap_status;
                        state      <= S_RESPOND;
                    end else if (opcode_q == OP_ACK) begin
                        rsp_data   <= '0;
                        rsp_status <= cap_status;
                        state      <= S_WAIT_CLR;
                    end else begin
                        state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (ack) begin
                        rsp_data   <= cap_reg_out;
                        rsp_status <= cap_status;
                        state      <= S_CLEAR;
                    end else if (to_hit) begin
                        rsp_timeout <= 1'b1;
                        rsp_data    <= '0;
                        rsp_status  <= cap_status;
                        state       <= S_RESPOND;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_CLEAR: state <= S_WAIT_CLR;
                S_WAIT_CLR: begin
                    if (!ack) begin
                        state <= S_RESPOND;
                    end else if (to_hit) begin
                        rsp_timeout <= 1'b1;
                        state       <= S_RESPOND;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_timeout <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
